// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the execute/memory requesters, the issue-stage
// claim port and the register-file write port of rf_wb_arbiter.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 claim_en;
  logic [4:0]           claim_rd;
  logic                 w_en;
  logic [4:0]           w_reg;
  logic [XLEN-1:0]      w_data;
  logic [31:0]          busy;

  modport master (
    output req_valid, req_rd, req_data, claim_en, claim_rd,
    input  req_ready, w_en, w_reg, w_data, busy
  );

  modport slave (
    input  req_valid, req_rd, req_data, claim_en, claim_rd,
    output req_ready, w_en, w_reg, w_data, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter and busy scoreboard for the 32 x XLEN register file.
// Grants one requester per cycle into a registered write stage and tracks
// outstanding destination registers for read-after-write stalls.
// Build option: define RF_WB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no pointer); default build is round-robin.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          rstn,
  rf_wb_arbiter_if.slave bus
);
  localparam int IDXW = (NREQ > 2) ? 2 : 1;

  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW:0]   cand;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            w_en_q;
  logic [4:0]      w_reg_q;
  logic [XLEN-1:0] w_data_q;
  logic [31:0]     busy_q;
  logic [31:0]     busy_nxt;

`ifndef RF_WB_FIXED_PRIO_EN
  logic [IDXW-1:0] ptr;
`endif

  // Pick the first valid requester, searching from the priority start point.
  always_comb begin
    grant_idx = '0;
    xfer      = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifndef RF_WB_FIXED_PRIO_EN
      cand = {1'b0, ptr} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
`else
      cand = (IDXW+1)'(k);
`endif
      if (!xfer && bus.req_valid[cand[IDXW-1:0]]) begin
        xfer      = 1'b1;
        grant_idx = cand[IDXW-1:0];
      end
    end
    grant = xfer ? (NREQ'(1) << grant_idx) : '0;
  end

  // Route the granted requester's destination and data to the write stage.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_rd   = bus.req_rd[5*k +: 5];
        sel_data = bus.req_data[XLEN*k +: XLEN];
      end
    end
  end

`ifndef RF_WB_FIXED_PRIO_EN
  // Advance the round-robin pointer past whoever just transferred.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr <= '0;
    else if (xfer) ptr <= (grant_idx == IDXW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  end
`endif

  // Registered write port; x0 writes are accepted but never enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_en_q   <= 1'b0;
      w_reg_q  <= '0;
      w_data_q <= '0;
    end else if (xfer) begin
      w_en_q   <= (sel_rd != 5'd0);
      w_reg_q  <= sel_rd;
      w_data_q <= sel_data;
    end else begin
      w_en_q   <= 1'b0;
    end
  end

  // Clear on the register-file write, then apply the claim so a same-cycle claim wins.
  always_comb begin
    busy_nxt = busy_q;
    if (w_en_q) busy_nxt[w_reg_q] = 1'b0;
    if (bus.claim_en && bus.claim_rd != 5'd0) busy_nxt[bus.claim_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy bitmap register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign bus.req_ready = grant;
  assign bus.w_en      = w_en_q;
  assign bus.w_reg     = w_reg_q;
  assign bus.w_data    = w_data_q;
  assign bus.busy      = busy_q;
endmodule
